// File: rtl/list_access_ctrl_pkg.sv
// Shared types and constants for the list access controller and its arbiter.
package list_pkg;

    typedef enum logic [1:0] {
        IDLE,
        READ_START,
        READ_WAIT
    } state_t;

    localparam int DEFAULT_MAX_LENGTH = 256;
    localparam int DEFAULT_WIDTH      = 2;

    // Address-style width: ceil(log2(x)), never less than one bit.
    function automatic int bits(input int x);
        return (x > 1) ? $clog2(x) : 1;
    endfunction

endpackage

// File: rtl/list_access_ctrl_if.sv
// Requester-facing bus of the list access controller: two push ports, one readback port, status.
interface list_access_if import list_pkg::*; #(
    parameter int MAX_LENGTH = DEFAULT_MAX_LENGTH,
    parameter int WIDTH      = DEFAULT_WIDTH
);

    logic                     req0;
    logic [WIDTH-1:0]         data0;
    logic                     gnt0;
    logic                     req1;
    logic [WIDTH-1:0]         data1;
    logic                     gnt1;
    logic                     rd_req;
    logic                     rd_gnt;
    logic                     rd_done;
    logic                     rd_err;
    logic                     busy;
    logic                     full;
    logic [bits(MAX_LENGTH):0] count;

    modport master (
        output req0, data0, req1, data1, rd_req,
        input  gnt0, gnt1, rd_gnt, rd_done, rd_err, busy, full, count
    );

    modport slave (
        input  req0, data0, req1, data1, rd_req,
        output gnt0, gnt1, rd_gnt, rd_done, rd_err, busy, full, count
    );

endinterface

// File: rtl/list_access_ctrl_rr_arb2.sv
// Two-way round-robin push arbiter; the pointer register lives in the parent.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       en,
    input  logic       rr_last,
    output logic [1:0] gnt,
    output logic       next_last
);

    // A lone requester wins without moving the pointer; only a tie rotates it.
    always_comb begin
        gnt       = 2'b00;
        next_last = rr_last;
        if (en) begin
            unique case (req)
                2'b01: gnt = 2'b01;
                2'b10: gnt = 2'b10;
                2'b11: begin
                    if (rr_last) begin
                        gnt       = 2'b01;
                        next_last = 1'b0;
                    end else begin
                        gnt       = 2'b10;
                        next_last = 1'b1;
                    end
                end
                default: gnt = 2'b00;
            endcase
        end
    end

endmodule

// File: rtl/list_access_ctrl.sv
// Shares one LIFO list between two push requesters and a readback requester,
// sequencing en_read -> read_done with a watchdog.
module list_access_ctrl import list_pkg::*; #(
    parameter int MAX_LENGTH = DEFAULT_MAX_LENGTH,
    parameter int WIDTH      = DEFAULT_WIDTH,
    parameter int RD_TIMEOUT = MAX_LENGTH + 8
) (
    input  logic             clk,
    input  logic             rst_n,
    list_access_if.slave     bus,
    output logic             list_push,
    output logic [WIDTH-1:0] list_data,
    output logic             list_en_read,
    input  logic             list_read_done
);

    localparam int CW  = bits(MAX_LENGTH) + 1;
    localparam int WDW = bits(RD_TIMEOUT) + 1;
    localparam logic [CW-1:0]  MAX_COUNT = CW'(MAX_LENGTH);
    localparam logic [WDW-1:0] WD_LAST   = WDW'(RD_TIMEOUT - 1);

    state_t         state, state_next;
    logic [CW-1:0]  count_q;
    logic [WDW-1:0] wd, wd_next;
    logic           rr_last;
    logic           rd_gnt_q, rd_done_q, rd_err_q, busy_q, en_read_q;
    logic           rd_gnt_next, rd_done_next, rd_err_next;
    logic           full_w;
    logic           arb_en;
    logic [1:0]     arb_gnt;
    logic           arb_next_last;

    assign full_w = (count_q == MAX_COUNT);

    // A pending readback always beats pushes, and nothing is pushed while a read is in flight.
    assign arb_en = (state == IDLE) && !bus.rd_req && !full_w;

    rr_arb2 u_arb (
        .req       ({bus.req1, bus.req0}),
        .en        (arb_en),
        .rr_last   (rr_last),
        .gnt       (arb_gnt),
        .next_last (arb_next_last)
    );

    assign bus.gnt0     = arb_gnt[0];
    assign bus.gnt1     = arb_gnt[1];
    assign list_push    = |arb_gnt;
    assign list_data    = arb_gnt[1] ? bus.data1 : bus.data0;
    assign list_en_read = en_read_q;

    assign bus.rd_gnt  = rd_gnt_q;
    assign bus.rd_done = rd_done_q;
    assign bus.rd_err  = rd_err_q;
    assign bus.busy    = busy_q;
    assign bus.full    = full_w;
    assign bus.count   = count_q;

    // An empty list is answered immediately since the list would ignore en_read anyway.
    always_comb begin
        state_next   = state;
        wd_next      = wd;
        rd_gnt_next  = 1'b0;
        rd_done_next = 1'b0;
        rd_err_next  = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.rd_req) begin
                    rd_gnt_next = 1'b1;
                    if (count_q == '0) begin
                        rd_done_next = 1'b1;
                    end else begin
                        state_next = READ_START;
                    end
                end
            end
            READ_START: begin
                state_next = READ_WAIT;
                wd_next    = '0;
            end
            READ_WAIT: begin
                if (list_read_done) begin
                    rd_done_next = 1'b1;
                    state_next   = IDLE;
                end else if (wd == WD_LAST) begin
                    rd_err_next = 1'b1;
                    state_next  = IDLE;
                end else begin
                    wd_next = wd + WDW'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            count_q   <= '0;
            rr_last   <= 1'b1;
            wd        <= '0;
            rd_gnt_q  <= 1'b0;
            rd_done_q <= 1'b0;
            rd_err_q  <= 1'b0;
            busy_q    <= 1'b0;
            en_read_q <= 1'b0;
        end else begin
            state     <= state_next;
            wd        <= wd_next;
            rd_gnt_q  <= rd_gnt_next;
            rd_done_q <= rd_done_next;
            rd_err_q  <= rd_err_next;
            busy_q    <= (state_next != IDLE);
            en_read_q <= (state_next == READ_START);
            if (list_push) begin
                count_q <= count_q + CW'(1);
                rr_last <= arb_next_last;
            end
        end
    end

endmodule

// File: tb/tb_list_access_ctrl.sv
// Randomized scoreboard bench for list_access_ctrl with a cycle-level reference of the sharing rules.
module tb_list_access_ctrl;
    import list_pkg::*;

    localparam int MAXL = 4;
    localparam int W    = 2;
    localparam int TMO  = 10;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic         list_push;
    logic [W-1:0] list_data;
    logic         list_en_read;
    logic         list_read_done = 1'b0;

    always #5 clk = ~clk;

    list_access_if #(.MAX_LENGTH(MAXL), .WIDTH(W)) bus ();

    list_access_ctrl #(.MAX_LENGTH(MAXL), .WIDTH(W), .RD_TIMEOUT(TMO)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .bus            (bus),
        .list_push      (list_push),
        .list_data      (list_data),
        .list_en_read   (list_en_read),
        .list_read_done (list_read_done)
    );

    typedef enum {EV_RGNT, EV_RDONE, EV_RERR, EV_EN, EV_PUSH} ev_kind_t;
    typedef struct {
        int       cyc;
        ev_kind_t kind;
        int       who;
        int       data;
    } ev_t;

    ev_t expq[$];
    int  checks  = 0;
    int  errors  = 0;
    int  cyc     = 0;
    int  n_rdone = 0;
    int  n_rerr  = 0;

    // Reference: a read is just "busy until cycle m_end"; pushes are counted, ties alternate.
    bit  m_reading   = 1'b0;
    int  m_end       = 0;
    int  m_busy_from = 0;
    int  m_done_cyc  = -1;
    int  m_count     = 0;
    int  m_last      = 1;
    bit  lrd         = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        bus.req0   = 1'b0;
        bus.req1   = 1'b0;
        bus.data0  = '0;
        bus.data1  = '0;
        bus.rd_req = 1'b0;
    end

    task automatic checkOutput(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic void expect_ev(input int c, input ev_kind_t k, input int who, input int data);
        ev_t e;
        e.cyc  = c;
        e.kind = k;
        e.who  = who;
        e.data = data;
        expq.push_back(e);
    endfunction

    function automatic void observe(input ev_kind_t k, input int who, input int data);
        ev_t e;
        checks++;
        if (expq.size() == 0) begin
            errors++;
            $display("[TB] FAIL sb_unexpected: got %s who=%0d data=%0d at cycle %0d, expected no event",
                     k.name(), who, data, cyc);
        end else begin
            e = expq.pop_front();
            if (e.cyc != cyc || e.kind != k || e.who != who || e.data != data) begin
                errors++;
                $display("[TB] FAIL sb_event: got %s who=%0d data=%0d cyc=%0d, expected %s who=%0d data=%0d cyc=%0d",
                         k.name(), who, data, cyc, e.kind.name(), e.who, e.data, e.cyc);
            end
        end
    endfunction

    // Monitor: every DUT output event is matched against the front of the expectation queue.
    always @(negedge clk) begin
        if (rst_n) begin
            while (expq.size() > 0 && expq[0].cyc < cyc) begin
                checks++;
                errors++;
                $display("[TB] FAIL sb_missing: got nothing, expected %s who=%0d data=%0d at cycle %0d",
                         expq[0].kind.name(), expq[0].who, expq[0].data, expq[0].cyc);
                void'(expq.pop_front());
            end
            if (bus.rd_gnt)  observe(EV_RGNT, 0, 0);
            if (bus.rd_done) begin
                n_rdone++;
                observe(EV_RDONE, 0, 0);
            end
            if (bus.rd_err) begin
                n_rerr++;
                observe(EV_RERR, 0, 0);
            end
            if (list_en_read) observe(EV_EN, 0, 0);
            if (bus.gnt0 || bus.gnt1 || list_push)
                observe(EV_PUSH, bus.gnt1 ? (bus.gnt0 ? 2 : 1) : (bus.gnt0 ? 0 : -1),
                        list_push ? int'(list_data) : -1);
        end
    end

    // One clock of stimulus; lat picks the list's read_done delay (0 = random, >TMO = never in time).
    task automatic applyStimulus(input bit r0, input logic [W-1:0] d0, input bit r1,
                                 input logic [W-1:0] d1, input bit rd, input int lat);
        int c;
        int who;
        int k;
        @(posedge clk);
        #1;
        c = cyc;
        if (m_reading && c >= m_end) m_reading = 1'b0;
        if (m_reading && c == m_busy_from + 1) lrd = 1'b0;
        if (m_reading && c == m_done_cyc) lrd = 1'b1;
        bus.req0       = r0;
        bus.data0      = d0;
        bus.req1       = r1;
        bus.data1      = d1;
        bus.rd_req     = rd;
        list_read_done = lrd;
        checkOutput("count", int'(bus.count), m_count);
        checkOutput("full", int'(bus.full), int'(m_count == MAXL));
        checkOutput("busy", int'(bus.busy), int'(m_reading && c >= m_busy_from));
        if (!m_reading) begin
            if (rd) begin
                expect_ev(c + 1, EV_RGNT, 0, 0);
                if (m_count == 0) begin
                    expect_ev(c + 1, EV_RDONE, 0, 0);
                end else begin
                    expect_ev(c + 1, EV_EN, 0, 0);
                    m_reading   = 1'b1;
                    m_busy_from = c + 1;
                    k = (lat == 0) ? int'($urandom_range(1, TMO + 2)) : lat;
                    if (k <= TMO) begin
                        m_done_cyc = c + 1 + k;
                        m_end      = c + 2 + k;
                        expect_ev(m_end, EV_RDONE, 0, 0);
                    end else begin
                        m_done_cyc = -1;
                        m_end      = c + 2 + TMO;
                        expect_ev(m_end, EV_RERR, 0, 0);
                    end
                end
            end else if (m_count < MAXL && (r0 || r1)) begin
                if (r0 && r1) begin
                    who    = (m_last == 1) ? 0 : 1;
                    m_last = who;
                end else begin
                    who = r0 ? 0 : 1;
                end
                expect_ev(c, EV_PUSH, who, (who == 0) ? int'(d0) : int'(d1));
                m_count++;
            end
        end
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, 1'b0, '0, 1'b0, 0);
    endtask

    task automatic drainQueue();
        int n;
        n = 0;
        while ((expq.size() > 0 || m_reading) && n < 40) begin
            applyStimulus(1'b0, '0, 1'b0, '0, 1'b0, 0);
            n++;
        end
        checkOutput("drain_pending", expq.size(), 0);
    endtask

    task automatic applyReset();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("rst_count", int'(bus.count), 0);
        checkOutput("rst_busy", int'(bus.busy), 0);
        checkOutput("rst_en_read", int'(list_en_read), 0);
        checkOutput("rst_rd_done", int'(bus.rd_done), 0);
        expq.delete();
        m_reading  = 1'b0;
        m_count    = 0;
        m_last     = 1;
        m_done_cyc = -1;
        lrd        = 1'b0;
        bus.req0   = 1'b0;
        bus.req1   = 1'b0;
        bus.rd_req = 1'b0;
        list_read_done = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        int rd0;
        int re0;
        #100000;
        $display("[TB] FAIL global_timeout: got no finish, expected finish before time limit");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        int rd0;
        int re0;
        applyReset();
        idleCycles(1);

        // Single requester, three back-to-back pushes.
        applyStimulus(1'b1, 2'd1, 1'b0, 2'd0, 1'b0, 0);
        applyStimulus(1'b1, 2'd2, 1'b0, 2'd0, 1'b0, 0);
        applyStimulus(1'b1, 2'd3, 1'b0, 2'd0, 1'b0, 0);
        idleCycles(1);
        checkOutput("count_after_3", int'(bus.count), 3);
        drainQueue();

        // Tie from reset: requester 0 first, then alternating, until full.
        applyReset();
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, W'(i), 1'b1, W'(3 - i), 1'b0, 0);
        applyStimulus(1'b1, 2'd1, 1'b1, 2'd2, 1'b0, 0);
        checkOutput("full_after_tie", int'(bus.full), 1);

        // Readback of a full list, rd_req dropped after the grant.
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b1, 4);
        for (int i = 0; i < 8; i++) applyStimulus(1'b1, 2'd2, 1'b0, '0, 1'b0, 0);
        drainQueue();
        checkOutput("count_after_read", int'(bus.count), 4);

        // Empty readback answered immediately, no en_read.
        applyReset();
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b1, 0);
        applyStimulus(1'b1, 2'd3, 1'b0, '0, 1'b0, 0);
        drainQueue();

        // Requester 1 overfills; then read and push together, read wins.
        applyReset();
        for (int i = 0; i < 6; i++) applyStimulus(1'b0, '0, 1'b1, W'(i), 1'b0, 0);
        drainQueue();
        applyReset();
        applyStimulus(1'b0, '0, 1'b1, 2'd1, 1'b0, 0);
        applyStimulus(1'b1, 2'd2, 1'b1, 2'd3, 1'b1, 2);
        for (int i = 0; i < 6; i++) applyStimulus(1'b1, 2'd2, 1'b1, 2'd3, 1'b0, 0);
        drainQueue();

        // Watchdog: read_done never arrives, and read_done exactly at the last allowed cycle.
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b1, TMO + 5);
        drainQueue();
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b1, TMO);
        drainQueue();

        // Reset in the middle of READ_WAIT: no completion or error afterwards.
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b1, TMO + 5);
        idleCycles(3);
        rd0 = n_rdone;
        re0 = n_rerr;
        applyReset();
        idleCycles(15);
        checkOutput("no_rd_done_after_reset", n_rdone, rd0);
        checkOutput("no_rd_err_after_reset", n_rerr, re0);
        drainQueue();

        // Random phases, each starting from reset.
        for (int p = 0; p < 5; p++) begin
            applyReset();
            for (int i = 0; i < 60; i++)
                applyStimulus(1'($urandom_range(0, 1)), W'($urandom_range(0, 3)),
                              1'($urandom_range(0, 1)), W'($urandom_range(0, 3)),
                              ($urandom_range(0, 7) == 0), 0);
            drainQueue();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
